// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES trace sequencer: FSM states, plaintext
// mode encodings and the 32-bit Galois LFSR definition.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_FVR    = 2'd2,
        MODE_RSVD   = 2'd3
    } seq_mode_e;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;
    localparam int unsigned LOAD_CYCLES   = 4;

    // Right-shifting Galois form: feedback taps applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/aes_seq_lfsr.sv
// 32-bit Galois LFSR with synchronous load and single-step advance; next_o exposes
// the value the register will hold after the current edge.
module aes_seq_lfsr
    import aes_seq_pkg::*;
#(
    parameter logic [31:0] RST_VAL = LFSR_SEED_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        step_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (step_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign next_o  = state_d;

endmodule

// File: rtl/aes_trace_sequencer.sv
// Drives an AES core through a run of encryptions for side-channel capture:
// fixed / random / fixed-vs-random plaintexts, scope trigger, inter-trace noise gap.
module aes_trace_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_CYCLES = 15,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [31:0] SEED_DEF   = LFSR_SEED_DEF
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              seq_start,
    input  logic              seq_abort,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_fixed_pt,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [31:0]       cfg_seed,
    input  logic [CNT_W-1:0]  cfg_num_traces,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [KEY_W-1:0]  AES_key_in,
    input  logic              AES_data_out_valid,
    input  logic [DATA_W-1:0] AES_data_out,
    output logic              trig,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_pt,
    output logic [DATA_W-1:0] res_ct,
    output logic              res_class,
    output logic [CNT_W-1:0]  res_idx,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned LC_W  = $clog2(LOAD_CYCLES);

    seq_state_e        state_q;
    seq_mode_e         mode_q;
    logic [DATA_W-1:0] fixed_q, rnd_q, data_in_q;
    logic [KEY_W-1:0]  key_q;
    logic [CNT_W-1:0]  num_q, idx_q;
    logic              cls_q;
    logic [LC_W-1:0]   load_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [GAP_W-1:0]  gap_q;
    logic              en_q, trig_q, busy_q, done_q, err_q;
    logic              res_valid_q, res_class_q;
    logic [DATA_W-1:0] res_pt_q, res_ct_q;
    logic [CNT_W-1:0]  res_idx_q;

    logic [DATA_W-1:0] rnd_d, pt_sel, noise;
    logic              cls_cur;
    logic [31:0]       lfsr_state, lfsr_next, seed_sel;
    logic              start_ok, lfsr_load, lfsr_adv;

    assign start_ok  = seq_start && (cfg_num_traces != '0);
    assign lfsr_load = start_ok && ((state_q == ST_IDLE) || ((state_q == ST_ERR) && !seq_abort));
    assign lfsr_adv  = (state_q == ST_LOAD) || (state_q == ST_GAP);
    assign seed_sel  = (cfg_seed == '0) ? SEED_DEF : cfg_seed;

    aes_seq_lfsr #(
        .RST_VAL(SEED_DEF)
    ) u_lfsr (
        .clk_i     (AES_clk),
        .rst_ni    (AES_rst_n),
        .load_i    (lfsr_load),
        .load_val_i(seed_sel),
        .step_i    (lfsr_adv),
        .state_o   (lfsr_state),
        .next_o    (lfsr_next)
    );

    // Class is decided on the first LOAD cycle and held in cls_q for the rest of the trace.
    always_comb begin
        rnd_d   = DATA_W'({rnd_q, lfsr_state});
        cls_cur = cls_q;
        if (load_cnt_q == '0) begin
            case (mode_q)
                MODE_RANDOM: cls_cur = 1'b1;
                MODE_FVR:    cls_cur = lfsr_state[0];
                default:     cls_cur = 1'b0;
            endcase
        end
        pt_sel = cls_cur ? rnd_d : fixed_q;
        noise  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            noise[i] = lfsr_next[i % 32];
        end
    end

    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_FIXED;
            fixed_q     <= '0;
            rnd_q       <= '0;
            data_in_q   <= '0;
            key_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            cls_q       <= 1'b0;
            load_cnt_q  <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            en_q        <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= 1'b0;
            res_pt_q    <= '0;
            res_ct_q    <= '0;
            res_idx_q   <= '0;
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (seq_abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                en_q    <= 1'b0;
                trig_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_ERR: begin
                        if (seq_start) begin
                            err_q <= 1'b0;
                            if (cfg_num_traces == '0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                mode_q     <= seq_mode_e'(cfg_mode);
                                fixed_q    <= cfg_fixed_pt;
                                key_q      <= cfg_key;
                                num_q      <= cfg_num_traces;
                                idx_q      <= '0;
                                load_cnt_q <= '0;
                                busy_q     <= 1'b1;
                                state_q    <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        rnd_q      <= rnd_d;
                        cls_q      <= cls_cur;
                        load_cnt_q <= load_cnt_q + LC_W'(1);
                        if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) begin
                            data_in_q <= pt_sel;
                            en_q      <= 1'b1;
                            trig_q    <= 1'b1;
                            tmo_q     <= '0;
                            state_q   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (AES_data_out_valid) begin
                            res_valid_q <= 1'b1;
                            res_pt_q    <= data_in_q;
                            res_ct_q    <= AES_data_out;
                            res_class_q <= cls_q;
                            res_idx_q   <= idx_q;
                            idx_q       <= idx_q + CNT_W'(1);
                            data_in_q   <= noise;
                            en_q        <= 1'b0;
                            trig_q      <= 1'b0;
                            gap_q       <= '0;
                            state_q     <= ST_GAP;
                        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            en_q    <= 1'b0;
                            trig_q  <= 1'b0;
                            state_q <= ST_ERR;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    ST_GAP: begin
                        data_in_q <= noise;
                        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                            if (idx_q < num_q) begin
                                load_cnt_q <= '0;
                                state_q    <= ST_LOAD;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign AES_en      = en_q;
    assign AES_data_in = data_in_q;
    assign AES_key_in  = key_q;
    assign trig        = trig_q;
    assign res_valid   = res_valid_q;
    assign res_pt      = res_pt_q;
    assign res_ct      = res_ct_q;
    assign res_class   = res_class_q;
    assign res_idx     = res_idx_q;
    assign seq_busy    = busy_q;
    assign seq_done    = done_q;
    assign seq_err     = err_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Scoreboard bench for aes_trace_sequencer with a mock XOR core and a trace-level
// reference model of the plaintext / class sequence.
module tb_aes_trace_sequencer;

    localparam int unsigned DW = 128;
    localparam int unsigned KW = 128;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seq_start = 1'b0, seq_abort = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_fixed_pt = '0;
    logic [KW-1:0] cfg_key = '0;
    logic [31:0]   cfg_seed = '0;
    logic [CW-1:0] cfg_num_traces = '0;
    logic          AES_en, trig, res_valid, res_class, seq_busy, seq_done, seq_err;
    logic [DW-1:0] AES_data_in, res_pt, res_ct;
    logic [KW-1:0] AES_key_in;
    logic [CW-1:0] res_idx;
    logic          mock_valid = 1'b0;
    logic [DW-1:0] mock_data = '0;
    logic          mock_on = 1'b1;
    int unsigned   mock_cnt = 0;

    aes_trace_sequencer dut (
        .AES_clk           (clk),
        .AES_rst_n         (rst_n),
        .seq_start         (seq_start),
        .seq_abort         (seq_abort),
        .cfg_mode          (cfg_mode),
        .cfg_fixed_pt      (cfg_fixed_pt),
        .cfg_key           (cfg_key),
        .cfg_seed          (cfg_seed),
        .cfg_num_traces    (cfg_num_traces),
        .AES_en            (AES_en),
        .AES_data_in       (AES_data_in),
        .AES_key_in        (AES_key_in),
        .AES_data_out_valid(mock_valid),
        .AES_data_out      (mock_data),
        .trig              (trig),
        .res_valid         (res_valid),
        .res_pt            (res_pt),
        .res_ct            (res_ct),
        .res_class         (res_class),
        .res_idx           (res_idx),
        .seq_busy          (seq_busy),
        .seq_done          (seq_done),
        .seq_err           (seq_err)
    );

    always #5 clk = ~clk;

    // Mock core: ciphertext = pt ^ key, one-cycle valid 10 cycles after enable rises.
    always @(posedge clk) begin
        if (!AES_en) mock_cnt <= 0;
        else         mock_cnt <= mock_cnt + 1;
        mock_valid <= mock_on && AES_en && (mock_cnt == 9);
        mock_data  <= AES_data_in ^ AES_key_in;
    end

    typedef struct {
        logic [DW-1:0] pt;
        logic [DW-1:0] ct;
        logic          cls;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int unsigned res_cnt = 0, done_cnt = 0, rise_cnt = 0, en_hi = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Trace-level model: 4 LFSR words per LOAD, then GAP_CYCLES further steps.
    task automatic model_push(input logic [1:0] mode, input logic [DW-1:0] fpt,
                              input logic [KW-1:0] key, input logic [31:0] seed, input int n);
        logic [31:0]   l;
        logic [DW-1:0] rnd;
        exp_t          e;
        l = (seed == 0) ? 32'h1 : seed;
        for (int i = 0; i < n; i++) begin
            e.cls = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? l[0] : 1'b0;
            for (int w = 0; w < 4; w++) begin
                rnd[DW-1-32*w -: 32] = l;
                l = model_step(l);
            end
            e.pt  = e.cls ? rnd : fpt;
            e.ct  = e.pt ^ key;
            e.idx = CW'(i);
            exp_q.push_back(e);
            for (int g = 0; g < 15; g++) l = model_step(l);
        end
    endtask

    task automatic monitor();
        int unsigned cyc = 0, last_rv = 0;
        bit          pending = 0;
        logic        en_prev = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_pt", res_pt, e.pt);
                    check_eq("res_ct", res_ct, e.ct);
                    check_eq("res_class", res_class, e.cls);
                    check_eq("res_idx", res_idx, e.idx);
                end
                last_rv = cyc;
                pending = 1;
            end
            if (seq_done) begin
                done_cnt++;
                if (pending) check_eq("gap_to_done", cyc - last_rv, 16);
                pending = 0;
            end else if (!seq_busy) begin
                pending = 0;
            end
            if (AES_en && !en_prev) begin
                rise_cnt++;
                if (pending) check_eq("gap_plus_load_len", cyc - last_rv, 19);
                pending = 0;
            end
            if (AES_en) en_hi++;
            en_prev = AES_en;
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [DW-1:0] fpt, input logic [KW-1:0] key,
                             input logic [31:0] seed, input int n, input bit push);
        cfg_mode       = mode;
        cfg_fixed_pt   = fpt;
        cfg_key        = key;
        cfg_seed       = seed;
        cfg_num_traces = CW'(n);
        if (push) model_push(mode, fpt, key, seed, n);
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [1:0] mode, input logic [DW-1:0] fpt,
                             input logic [KW-1:0] key, input logic [31:0] seed, input int n,
                             input int unsigned budget, input bit poke);
        int unsigned d0, r0, e0, k;
        d0 = done_cnt; r0 = res_cnt; e0 = rise_cnt; k = 0;
        start_run(mode, fpt, key, seed, n, 1'b1);
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
            if (poke && k == 60) begin
                // A start while busy, with different cfg, must not disturb the run.
                cfg_mode = 2'd0; cfg_num_traces = 16'd5; cfg_key = '0; cfg_seed = 32'hdead_beef;
                seq_start = 1'b1;
                @(negedge clk);
                seq_start = 1'b0;
            end
        end
        check_eq({tag, "_done_in_budget"}, (done_cnt != d0), 1);
        repeat (5) @(negedge clk);
        check_eq({tag, "_done_count"}, done_cnt - d0, 1);
        check_eq({tag, "_res_count"}, res_cnt - r0, n);
        check_eq({tag, "_en_windows"}, rise_cnt - e0, n);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
        check_eq({tag, "_idle_busy"}, seq_busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, AES_en, 0);
        check_eq({tag, "_trig"}, trig, 0);
        check_eq({tag, "_data_in"}, AES_data_in, 0);
        check_eq({tag, "_key_in"}, AES_key_in, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_pt"}, res_pt, 0);
        check_eq({tag, "_res_ct"}, res_ct, 0);
        check_eq({tag, "_res_class"}, res_class, 0);
        check_eq({tag, "_res_idx"}, res_idx, 0);
        check_eq({tag, "_busy"}, seq_busy, 0);
        check_eq({tag, "_done"}, seq_done, 0);
        check_eq({tag, "_err"}, seq_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, r0, e0, k;
        logic [DW-1:0] rpt;
        logic [KW-1:0] rkey;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_check("zero_n", 2'd0, '1, '1, 32'h5, 0, 10, 1'b0);

        run_check("fixed_vec", 2'd0, 128'h000000ee_00000000_00000000_00000000,
                  128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, 32'h0, 1, 200, 1'b0);

        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_check("random_seed0", 2'd1, '0, rkey, 32'h0, 3, 300, 1'b0);

        rpt  = {$urandom, $urandom, $urandom, $urandom};
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_check("fvr_256", 2'd2, rpt, rkey, $urandom, 256, 20000, 1'b1);

        for (int it = 0; it < 4; it++) begin
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_check("rand_run", 2'($urandom_range(0, 3)), rpt, rkey,
                      (it == 1) ? 32'h0 : $urandom, int'($urandom_range(1, 4)), 400, 1'b0);
        end

        // Timeout: the core never answers.
        mock_on = 1'b0;
        e0 = en_hi;
        k  = 0;
        start_run(2'd0, '1, '1, 32'h7, 1, 1'b0);
        while (!seq_err && k < 1200) begin
            @(negedge clk);
            k++;
        end
        check_eq("timeout_err_set", seq_err, 1);
        check_eq("timeout_run_cycles", en_hi - e0, 1024);
        check_eq("timeout_en_low", AES_en, 0);
        check_eq("timeout_busy", seq_busy, 1);
        mock_on = 1'b1;
        d0 = done_cnt; r0 = res_cnt; k = 0;
        rkey = {$urandom, $urandom, $urandom, $urandom};
        start_run(2'd1, '0, rkey, $urandom, 1, 1'b1);
        check_eq("err_cleared_by_start", seq_err, 0);
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("after_err_res_count", res_cnt - r0, 1);

        // Abort at RUN cycle 3.
        repeat (3) @(negedge clk);
        d0 = done_cnt; r0 = res_cnt; k = 0;
        start_run(2'd1, '0, '1, 32'h9, 2, 1'b0);
        while (!AES_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_en_seen", AES_en, 1);
        repeat (2) @(negedge clk);
        seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
        check_eq("abort_busy", seq_busy, 0);
        check_eq("abort_en", AES_en, 0);
        check_eq("abort_err_kept", seq_err, 0);
        repeat (60) @(negedge clk);
        check_eq("abort_no_res", res_cnt - r0, 0);
        check_eq("abort_no_done", done_cnt - d0, 0);

        // Reset during GAP.
        r0 = res_cnt; k = 0;
        start_run(2'd0, {$urandom, $urandom, $urandom, $urandom}, '1, 32'h3, 2, 1'b1);
        while (res_cnt == r0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("gap_first_res", res_cnt - r0, 1);
        repeat (5) @(negedge clk);
        d0 = done_cnt; r0 = res_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        exp_q.delete();
        repeat (60) @(negedge clk);
        check_eq("reset_no_res", res_cnt - r0, 0);
        check_eq("reset_no_done", done_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
